wb_cmd_master: RTL and testbench

Wishbone classic single-transfer initiator, the bus-master counterpart of the user project's `wbs_*` slave port. It converts a valid/ready command stream (from an on-chip debug/bring-up sequencer or logic-analyzer bridge) into one Wishbone read or write cycle per command. It returns the read data, or an error flag on bus timeout, on a valid/ready response stream. It sits between a command source and any Wishbone slave in the design, such as the LED controller register bank.

---
 rtl/wb_cmd_master.sv | 96 +++++++++
 tb/tb_wb_cmd_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one valid/ready command in, one bus
// cycle out, one valid/ready response back (read data or timeout error).
module wb_cmd_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    // TIMEOUT=0 still needs a legal one-bit counter even though it is never compared.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        cnt       <= '0;
                        state     <= BUS;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                BUS: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (wbm_ack_i || (TIMEOUT != 0 && cnt == CW'(TIMEOUT))) begin
                        rsp_dat   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : 32'd0;
                        rsp_err   <= !wbm_ack_i;
                        rsp_valid <= 1'b1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_adr_o <= '0;
                        wbm_dat_o <= '0;
                        wbm_sel_o <= '0;
                        state     <= RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed vector table, hand-written corner sequences and
// randomized transfers checked against a transaction-level model.
module tb_wb_cmd_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o;
    logic [3:0]  sel;
    logic [31:0] dat_i = '0;
    logic        ack = 1'b0;

    int checks = 0;
    int errors = 0;

    wb_cmd_master #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
        .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_dly;   // ack driven in stb cycle ack_dly+1; >=50 means never
        logic [31:0] rdata;
        int          bp;        // cycles rsp_ready held low
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_stb;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int wait_n = 0;
        while (!cmd_ready && wait_n < 20) begin
            step();
            wait_n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
        step();
        cmd_valid = 1'b0;
        cmd_we = $urandom; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
        chk("cmd_ready_after_hs", cmd_ready, 0);
    endtask

    task automatic run_bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int ack_dly, input logic [31:0] rdata,
                           output int n);
        n = 0;
        while (stb && n < 50) begin
            n++;
            chk("bus_cyc", cyc, 1);
            chk("bus_we", we, w);
            chk("bus_adr", adr, a);
            chk("bus_dat", dat_o, d);
            chk("bus_sel", sel, s);
            chk("bus_rsp_valid", rsp_valid, 0);
            ack = (n == ack_dly + 1);
            dat_i = rdata;
            step();
        end
        ack = 1'b0;
        dat_i = $urandom;
        chk("post_cyc", cyc, 0);
        chk("post_bus_zero", {we, adr, dat_o, sel} == '0, 1);
    endtask

    task automatic finish_rsp(input int bp, input logic late_ack,
                              input logic [31:0] exp_dat, input logic exp_err);
        for (int i = 0; i < bp; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_dat", rsp_dat, exp_dat);
            chk("bp_rsp_err", rsp_err, exp_err);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_stb", stb, 0);
            rsp_ready = 1'b0;
            ack = late_ack;
            dat_i = 32'hFFFF_FFFF;
            step();
        end
        ack = 1'b0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_dat", rsp_dat, exp_dat);
        chk("rsp_err", rsp_err, exp_err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_done_valid", rsp_valid, 0);
        chk("rsp_done_cmd_ready", cmd_ready, 1);
        chk("rsp_done_stb", stb, 0);
    endtask

    task automatic xfer(input vec_t v, input logic late_ack);
        int n;
        issue_cmd(v.we, v.adr, v.dat, v.sel);
        chk("stb_after_hs", stb, 1);
        run_bus(v.we, v.adr, v.dat, v.sel, v.ack_dly, v.rdata, n);
        chk("stb_cycles", n, v.exp_stb);
        finish_rsp(v.bp, late_ack, v.exp_dat, v.exp_err);
    endtask

    initial begin
        vec_t v;
        int   n;

        vecs[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 1,  32'hDEAD_BEEF, 0,  32'h0,         1'b0, 2};
        vecs[1] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 0,  32'hCAFE_F00D, 0,  32'hCAFE_F00D, 1'b0, 1};
        vecs[2] = '{1'b0, 32'h3000_000C, 32'h0,         4'h3, 99, 32'h1111_2222, 0,  32'h0,         1'b1, TO + 1};
        vecs[3] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, TO, 32'h1234_5678, 0,  32'h1234_5678, 1'b0, TO + 1};
        vecs[4] = '{1'b0, 32'h3000_0014, 32'h0,         4'hC, 2,  32'h0BAD_F00D, 10, 32'h0BAD_F00D, 1'b0, 3};
        vecs[5] = '{1'b1, 32'h3000_0018, 32'h5555_AAAA, 4'h1, 99, 32'h7777_7777, 2,  32'h0,         1'b1, TO + 1};

        // reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp", {rsp_err, rsp_dat}, 0);
        chk("rst_bus", {cyc, stb, we, adr, dat_o, sel} == '0, 1);
        rst = 1'b0;
        step();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // ack while idle must not start anything
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("idle_ack_stb", stb, 0);
        chk("idle_ack_rsp", rsp_valid, 0);

        foreach (vecs[i]) xfer(vecs[i], 1'b0);

        // timeout followed by late ack pulses while the response waits
        v = '{1'b0, 32'h3000_0020, 32'h0, 4'hF, 99, 32'h0, 3, 32'h0, 1'b1, TO + 1};
        xfer(v, 1'b1);

        // reset in the second strobe cycle abandons the transfer
        issue_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF);
        chk("rstbus_stb1", stb, 1);
        step();
        chk("rstbus_stb2", stb, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstbus_cyc", cyc, 0);
        chk("rstbus_stb", stb, 0);
        chk("rstbus_rsp_valid", rsp_valid, 0);
        chk("rstbus_cmd_ready", cmd_ready, 0);
        step();
        chk("rstbus_cmd_ready_after", cmd_ready, 1);
        chk("rstbus_no_rsp", rsp_valid, 0);
        v = '{1'b0, 32'h3000_0028, 32'h0, 4'hF, 1, 32'h600D_DA7A, 0, 32'h600D_DA7A, 1'b0, 2};
        xfer(v, 1'b0);

        // randomized transfers against the transaction-level model
        for (int k = 0; k < 60; k++) begin
            v.we      = 1'($urandom);
            v.adr     = $urandom;
            v.dat     = $urandom;
            v.sel     = 4'($urandom);
            v.ack_dly = $urandom_range(0, TO + 3);
            v.rdata   = $urandom;
            v.bp      = $urandom_range(0, 3);
            v.exp_err = (v.ack_dly > TO);
            v.exp_stb = v.exp_err ? TO + 1 : v.ack_dly + 1;
            v.exp_dat = (v.exp_err || v.we) ? 32'h0 : v.rdata;
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin
                ack = 1'($urandom);
                step();
                ack = 1'b0;
                chk("rand_idle_stb", stb, 0);
            end
            xfer(v, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
